// File: rtl/pll_sys_pkg.sv
// Shared types and default timing constants for the system PLL supervisor.
// Contents:
//   pll_state_t      - supervisor FSM state encoding (also exported on the debug port)
//   PLL_RST_CYCLES   - default PLL reset pulse width in refclk cycles
//   PLL_LOCK_FILTER  - default number of consecutive locked cycles before release
//   PLL_LOCK_TIMEOUT - default number of cycles to wait for a first lock
//   FAULT_MAX        - saturation value of the fault counter
package pll_sys_pkg;

   typedef enum logic [1:0] {
      RESET     = 2'd0,
      WAIT_LOCK = 2'd1,
      FILTER    = 2'd2,
      RUN       = 2'd3
   } pll_state_t;

   localparam int PLL_RST_CYCLES   = 16;
   localparam int PLL_LOCK_FILTER  = 1024;
   localparam int PLL_LOCK_TIMEOUT = 1000000;

   localparam logic [7:0] FAULT_MAX = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset to 0.
// Ports:
//   clk - destination-domain clock
//   rst - asynchronous active-high reset, clears both flops
//   d   - asynchronous input bit
//   q   - synchronised output, two clk edges behind d
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // First flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_sys_reset_ctrl.sv
// Power-up and lock supervisor for the system PLL, running on the reference clock.
// Pulses the PLL reset, waits for a filtered lock, then releases sys_rst/ready.
// Restarts the PLL on lock loss, lock timeout or a software retry, and keeps a
// saturating count of lock losses plus timeouts.
// Ports:
//   refclk      - reference clock, the only clock
//   rst         - asynchronous active-high reset
//   pll_locked  - PLL locked flag, asynchronous
//   retry       - single-cycle request to restart the PLL
//   pll_rst     - reset to the PLL, high while in RESET
//   sys_rst     - active-high system reset, always !ready
//   ready       - PLL locked and filtered
//   fault_count - saturating count of lock losses plus timeouts
//   state       - current FSM state for debug
module pll_sys_reset_ctrl
   import pll_sys_pkg::*;
#(
   parameter int RST_CYCLES   = PLL_RST_CYCLES,
   parameter int LOCK_FILTER  = PLL_LOCK_FILTER,
   parameter int LOCK_TIMEOUT = PLL_LOCK_TIMEOUT,
   parameter int CNT_W        = 20
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       retry,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic [7:0] fault_count,
   output logic [1:0] state
);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

   pll_state_t       state_q;
   pll_state_t       state_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic             fault_inc;
   logic             lock_s;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   // Next-state logic. Within each state a lock event wins over timeout or
   // filter completion, which in turn wins over retry, so a retry coinciding
   // with lock loss still counts as a fault. The shared counter restarts on
   // every state change, so a glitch in FILTER gives a fresh timeout budget.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q + CNT_W'(1);
      fault_inc = 1'b0;
      case (state_q)
         RESET: begin
            if (cnt_q == RST_LAST) state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt = FILTER;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_nxt = RESET;
               fault_inc = 1'b1;
            end else if (retry) begin
               state_nxt = RESET;
            end
         end
         FILTER: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
            end else if (cnt_q == FILTER_LAST) begin
               state_nxt = RUN;
            end else if (retry) begin
               state_nxt = RESET;
            end
         end
         RUN: begin
            cnt_nxt = cnt_q;
            if (!lock_s) begin
               state_nxt = RESET;
               fault_inc = 1'b1;
            end else if (retry) begin
               state_nxt = RESET;
            end
         end
         default: state_nxt = RESET;
      endcase
      if (state_nxt != state_q) cnt_nxt = '0;
   end

   // State, counter, fault counter and outputs. Outputs are registered from
   // the next state so they change on the same edge as the state register.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q     <= RESET;
         cnt_q       <= '0;
         fault_count <= 8'd0;
         pll_rst     <= 1'b1;
         sys_rst     <= 1'b1;
         ready       <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         if (fault_inc && (fault_count != FAULT_MAX)) begin
            fault_count <= fault_count + 8'd1;
         end
         pll_rst <= (state_nxt == RESET);
         sys_rst <= (state_nxt != RUN);
         ready   <= (state_nxt == RUN);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pll_sys_reset_ctrl.sv
// Directed self-checking bench for pll_sys_reset_ctrl with small timing
// parameters (reset pulse 4, lock filter 8, lock timeout 32). Inputs are
// driven and outputs sampled on the falling edge of refclk.
module tb_pll_sys_reset_ctrl;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       retry;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic [7:0] fault_count;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;

   pll_sys_reset_ctrl #(
      .RST_CYCLES   (4),
      .LOCK_FILTER  (8),
      .LOCK_TIMEOUT (32),
      .CNT_W        (20)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .retry       (retry),
      .pll_rst     (pll_rst),
      .sys_rst     (sys_rst),
      .ready       (ready),
      .fault_count (fault_count),
      .state       (state)
   );

   // 50 MHz reference clock.
   initial refclk = 1'b0;
   always #10 refclk = ~refclk;

   task automatic applyStimulus(input logic new_rst, input logic new_locked, input logic new_retry);
      rst        = new_rst;
      pll_locked = new_locked;
      retry      = new_retry;
   endtask

   task automatic stepClocks(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [1:0] exp_state, input logic exp_ready,
                           input logic exp_pll_rst, input logic [7:0] exp_fault);
      checkOutput({tag, ".state"}, 32'(state), 32'(exp_state));
      checkOutput({tag, ".ready"}, 32'(ready), 32'(exp_ready));
      checkOutput({tag, ".sys_rst"}, 32'(sys_rst), 32'(!exp_ready));
      checkOutput({tag, ".pll_rst"}, 32'(pll_rst), 32'(exp_pll_rst));
      checkOutput({tag, ".fault_count"}, 32'(fault_count), 32'(exp_fault));
   endtask

   // Counts consecutive falling-edge samples with pll_rst high, bounded.
   task automatic measurePllRst(output int width);
      width = 0;
      while (pll_rst === 1'b1 && width < 20) begin
         width++;
         stepClocks(1);
      end
   endtask

   initial begin
      int width;

      // Reset state
      applyStimulus(1'b1, 1'b0, 1'b0);
      stepClocks(3);
      checkAll("reset", 2'd0, 1'b0, 1'b1, 8'd0);

      // Power-up: 4-cycle PLL reset pulse from release
      applyStimulus(1'b0, 1'b0, 1'b0);
      measurePllRst(width);
      checkOutput("powerup.pll_rst_width", 32'(width), 32'd4);
      checkOutput("powerup.state_wait", 32'(state), 32'd1);

      // Lock rises 10 cycles after release; ready 11 edges later
      stepClocks(6);
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepClocks(3);
      checkOutput("powerup.state_filter", 32'(state), 32'd2);
      stepClocks(7);
      checkAll("powerup.before_ready", 2'd2, 1'b0, 1'b0, 8'd0);
      stepClocks(1);
      checkAll("powerup.ready", 2'd3, 1'b1, 1'b0, 8'd0);

      // Lock loss in RUN: visible 3 edges after the drop
      applyStimulus(1'b0, 1'b0, 1'b0);
      stepClocks(2);
      checkAll("lockloss.edge2", 2'd3, 1'b1, 1'b0, 8'd0);
      stepClocks(1);
      checkAll("lockloss.edge3", 2'd0, 1'b0, 1'b1, 8'd1);

      // Re-lock: 4 reset cycles, 1 edge to FILTER, 8 filter cycles
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepClocks(12);
      checkOutput("relock.before_ready", 32'(ready), 32'd0);
      stepClocks(1);
      checkAll("relock.ready", 2'd3, 1'b1, 1'b0, 8'd1);

      // Retry in RUN: restart without counting
      applyStimulus(1'b0, 1'b1, 1'b1);
      stepClocks(1);
      checkAll("retry_run", 2'd0, 1'b0, 1'b1, 8'd1);

      // Retry in RESET is ignored: release timing unchanged
      applyStimulus(1'b0, 1'b1, 1'b1);
      stepClocks(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("retry_reset.state", 32'(state), 32'd0);
      stepClocks(11);
      checkOutput("retry_reset.before_ready", 32'(ready), 32'd0);
      stepClocks(1);
      checkAll("retry_reset.ready", 2'd3, 1'b1, 1'b0, 8'd1);

      // Retry coinciding with lock loss: one transition, fault counted
      applyStimulus(1'b0, 1'b0, 1'b0);
      stepClocks(2);
      applyStimulus(1'b0, 1'b0, 1'b1);
      stepClocks(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkAll("retry_lockloss", 2'd0, 1'b0, 1'b1, 8'd2);
      stepClocks(12);
      checkOutput("retry_lockloss.before_ready", 32'(ready), 32'd0);
      stepClocks(1);
      checkAll("retry_lockloss.ready", 2'd3, 1'b1, 1'b0, 8'd2);

      // Get back to WAIT_LOCK with lock low
      applyStimulus(1'b0, 1'b0, 1'b0);
      stepClocks(3);
      checkOutput("glitch_setup.fault", 32'(fault_count), 32'd3);
      stepClocks(4);
      checkOutput("glitch_setup.state", 32'(state), 32'd1);

      // Glitchy lock: one-cycle drop after 5 locked cycles in FILTER
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepClocks(6);
      applyStimulus(1'b0, 1'b0, 1'b0);
      stepClocks(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepClocks(1);
      checkOutput("glitch.still_filter", 32'(state), 32'd2);
      stepClocks(1);
      checkAll("glitch.back_to_wait", 2'd1, 1'b0, 1'b0, 8'd3);
      stepClocks(8);
      checkAll("glitch.before_ready", 2'd2, 1'b0, 1'b0, 8'd3);
      stepClocks(1);
      checkAll("glitch.ready", 2'd3, 1'b1, 1'b0, 8'd3);

      // Timeout: lock lost and held low
      applyStimulus(1'b0, 1'b0, 1'b0);
      stepClocks(3);
      checkOutput("timeout.enter_reset_fault", 32'(fault_count), 32'd4);
      stepClocks(35);
      checkAll("timeout.last_wait", 2'd1, 1'b0, 1'b0, 8'd4);
      stepClocks(1);
      checkAll("timeout.expired", 2'd0, 1'b0, 1'b1, 8'd5);
      measurePllRst(width);
      checkOutput("timeout.pll_rst_width", 32'(width), 32'd4);
      stepClocks(360);
      checkAll("timeout.ten_loops", 2'd1, 1'b0, 1'b0, 8'd15);
      stepClocks(300 * 36);
      checkAll("timeout.saturated", 2'd1, 1'b0, 1'b0, 8'd255);

      // Asynchronous reset mid-FILTER, between clock edges
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepClocks(5);
      checkOutput("async.in_filter", 32'(state), 32'd2);
      #5;
      applyStimulus(1'b1, 1'b1, 1'b0);
      #1;
      checkAll("async.immediate", 2'd0, 1'b0, 1'b1, 8'd0);
      stepClocks(2);
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepClocks(1);
      checkAll("async.after_release", 2'd0, 1'b0, 1'b1, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pll_sys_reset_ctrl.md
# pll_sys_reset_ctrl

Power-up and lock supervisor for the 96 MHz system PLL. Runs on the 50 MHz reference clock, pulses the PLL reset, waits for a stable `locked`, and only then releases the system reset and `ready`. Restarts the PLL on lock loss, lock timeout or software retry, and counts fault events. Sits between the board reset input and the PLL wrapper; downstream logic re-synchronises `sys_rst` into the `outclk_0` domain.

## Interface
- `RST_CYCLES`, 16 — PLL reset pulse width in `refclk` cycles, minimum 1.
- `LOCK_FILTER`, 1024 — consecutive synced-locked cycles required before release, minimum 1.
- `LOCK_TIMEOUT`, 1000000 — cycles to wait for the first lock before retrying, minimum 1.
- `CNT_W`, 20 — shared counter width; must hold the largest of the three values above.

- `refclk` in 1 — 50 MHz reference clock; the only clock.
- `rst` in 1 — asynchronous, active-high reset.
- `pll_locked` in 1 — PLL `locked`; asynchronous, synchronised internally.
- `retry` in 1 — synchronous single-cycle request to restart the PLL.
- `pll_rst` out 1 — drives the PLL `rst`.
- `sys_rst` out 1 — active-high system reset; equals `!ready`.
- `ready` out 1 — PLL locked and filtered.
- `fault_count` out 8 — saturating count of lock losses plus timeouts.
- `state` out 2 — current FSM state, for debug.

## Operation
- FSM states:
  - RESET = 0: `pll_rst`=1.
  - WAIT_LOCK = 1.
  - FILTER = 2.
  - RUN = 3: `ready`=1.
- A single counter `cnt` of width `CNT_W` clears on every state change.
- `lock_s` is `pll_locked` passed through a 2-flop synchroniser.
- RESET:
  - counts to `RST_CYCLES`-1, then goes to WAIT_LOCK.
  - `retry` is ignored.
- WAIT_LOCK:
  - `lock_s`=1 goes to FILTER.
  - Otherwise, when `cnt` reaches `LOCK_TIMEOUT`-1, goes to RESET and increments `fault_count`.
  - `retry` goes to RESET with no count.
- FILTER:
  - `lock_s`=0 goes back to WAIT_LOCK. Neither `cnt` nor the timeout budget carries over.
  - After `LOCK_FILTER` consecutive cycles with `lock_s`=1, goes to RUN.
  - `retry` goes to RESET with no count.
- RUN:
  - `lock_s`=0 goes to RESET and increments `fault_count`.
  - `retry` goes to RESET with no count.
  - If both occur in the same cycle, one transition is taken and the fault is counted.
- Priority in every state: `lock_s` event, then timeout or filter completion, then `retry`.
- `fault_count` saturates at 255. It is cleared only by `rst`.
- All outputs are registered and decoded from the state register. There is no combinational path from input to output.

## Timing
- Reset values while `rst`=1:
  - `state`=RESET, `cnt`=0
  - `pll_rst`=1, `sys_rst`=1, `ready`=0
  - `fault_count`=0
  - synchroniser flops = 0
- `rst` assertion takes effect immediately (asynchronous). Release is synchronous to the next `refclk` edge.
- `pll_rst` stays high for exactly `RST_CYCLES` cycles after the first edge following `rst` release.
- Lock detection latency: 2 cycles of synchronisation, plus 1 edge for the state change.
- Release in the fastest case: `ready` rises `LOCK_FILTER` cycles after entering FILTER. `sys_rst` falls on the same edge.
- Lock loss in RUN:
  - `ready`=0, `sys_rst`=1 and `pll_rst`=1 appear 3 edges after `pll_locked` falls.
  - `fault_count` updates on the same edge.
- `rst` asserted mid-sequence: immediate return to reset values from any state.

## Structure
- Package `pll_sys_pkg` holds:
  - the `pll_state_t` enum (RESET, WAIT_LOCK, FILTER, RUN; 2 bits);
  - default constants `PLL_RST_CYCLES`, `PLL_LOCK_FILTER`, `PLL_LOCK_TIMEOUT`.
- One sub-module: `sync_2ff`, a single-bit 2-flop synchroniser with asynchronous reset to 0. It is reused by consumers for `sys_rst` in the `outclk_0` domain.
- The rest is one FSM plus the counter and fault-count registers.

## Test plan
Benches use `RST_CYCLES`=4, `LOCK_FILTER`=8, `LOCK_TIMEOUT`=32.
- **Power-up:** release `rst`, raise `pll_locked` 10 cycles later and hold it.
  - `pll_rst` high for exactly 4 cycles.
  - `ready`=1 and `sys_rst`=0 exactly 2+1+8 cycles after `pll_locked` rises.
  - `fault_count`=0.
- **Glitchy lock:** in FILTER, drop `pll_locked` for 1 cycle after 5 locked cycles.
  - Returns to WAIT_LOCK.
  - `ready` stays 0 until 8 fresh consecutive locked cycles.
- **Timeout:** hold `pll_locked`=0.
  - WAIT_LOCK times out after 32 cycles, then a new 4-cycle `pll_rst` pulse.
  - `fault_count` increments by 1 per loop.
  - After 300 loops it reads 255.
- **Lock loss in RUN:** drop `pll_locked`.
  - 3 edges later: `ready`=0, `sys_rst`=1, `pll_rst`=1, `fault_count`+1.
  - Then a full re-lock sequence.
- **Retry:**
  - A pulse in RUN causes RESET with `fault_count` unchanged.
  - A pulse in the same cycle as lock loss causes a single transition with `fault_count`+1.
  - A pulse in RESET is ignored.
- **Asynchronous reset:** assert `rst` mid-FILTER between clock edges.
  - Outputs go to reset values before the next edge.
  - `fault_count` returns to 0.
